// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the fetch stage: FSM encoding, the
// reset-time instruction and the default boot address.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory read channel: the fetch stage is the master, the
// memory (with optional wait states) is the slave.
interface pc_fetch_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [31:0]     imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/pc_fetch_next_pc_sel.sv
// Combinational next-PC mux: JALR beats PC-relative branch beats
// sequential fall-through; also flags targets that are not word aligned.
module pc_fetch_next_pc_sel #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    input  logic            br_taken,
    input  logic            jalr,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);
    logic [XLEN-1:0] jalr_sum;

    always_comb begin
        jalr_sum = rs1_val + imm;
        if (jalr) begin
            // JALR drops bit 0 of the sum before use
            next_pc = {jalr_sum[XLEN-1:1], 1'b0};
        end else if (br_taken) begin
            next_pc = pc + imm;
        end else begin
            next_pc = pc + XLEN'(4);
        end
        misaligned = (next_pc[1:0] != 2'b00);
    end

endmodule

// File: rtl/pc_fetch.sv
// RISC-V fetch stage: PC register, instruction-memory handshake, held
// instruction for decode, retired-instruction counter and misalign trap.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    pc_fetch_if.master      imem,
    output logic [31:0]     instr,
    output logic            instr_valid,
    input  logic            instr_ack,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    input  logic            br_taken,
    input  logic            jalr,
    output logic            fetch_err,
    output logic [31:0]     instret
);
    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic [31:0]     instret_q, instret_d;
    logic [XLEN-1:0] next_pc;
    logic            next_misaligned;

    pc_fetch_next_pc_sel #(.XLEN(XLEN)) u_next_pc_sel (
        .pc         (pc_q),
        .imm        (imm),
        .rs1_val    (rs1_val),
        .br_taken   (br_taken),
        .jalr       (jalr),
        .next_pc    (next_pc),
        .misaligned (next_misaligned)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        err_d     = err_q;
        instret_d = instret_q;
        case (state_q)
            FETCH: begin
                if (imem.imem_ready) begin
                    instr_d = imem.imem_rdata;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (instr_ack) begin
                    valid_d = 1'b0;
                    // a bad target traps with the PC left on the jumping instruction
                    if (next_misaligned) begin
                        err_d   = 1'b1;
                        state_d = HALT;
                    end else begin
                        pc_d      = next_pc;
                        instret_d = instret_q + 32'd1;
                        state_d   = FETCH;
                    end
                end
            end
            HALT: begin
                valid_d = 1'b0;
                err_d   = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            pc_q      <= XLEN'(RESET_PC);
            instr_q   <= NOP_INSTR;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            instret_q <= instret_d;
        end
    end

    // rst gates the request directly so it drops mid-cycle on an async reset
    assign imem.imem_req  = (state_q == FETCH) && !rst;
    assign imem.imem_addr = pc_q;
    assign instr          = instr_q;
    assign instr_valid    = valid_q;
    assign pc_out         = pc_q;
    assign pc_plus4       = pc_q + XLEN'(4);
    assign fetch_err      = err_q;
    assign instret        = instret_q;

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Fetch stage of the RISC-V core: owns the PC register, issues instruction-memory reads and holds the fetched instruction for decode and the immediate generator.
- Computes the next PC from the immediate produced by genInm together with branch and JALR controls.
- Sits directly upstream of decode/genInm and directly downstream of genInm's imm_out, which feeds back for target calculation.
- Supports instruction memory with wait states through a req/ready handshake.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be 4-byte aligned.
- XLEN, 32: datapath width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- imem_req  out  1  instruction read request.
- imem_addr  out  XLEN  read address; equals pc_out.
- imem_ready  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  instruction word.
- instr  out  32  held instruction, to decode and genInm.
- instr_valid  out  1  instr is valid.
- instr_ack  in  1  core has executed instr this cycle.
- pc_out  out  XLEN  PC of the current instruction.
- pc_plus4  out  XLEN  pc_out + 4, for JAL/JALR writeback.
- imm  in  XLEN  sign-extended immediate from genInm.
- rs1_val  in  XLEN  rs1 operand, used for JALR.
- br_taken  in  1  take PC-relative target (B-type or JAL).
- jalr  in  1  take register-relative target.
- fetch_err  out  1  sticky misaligned-target flag.
- instret  out  32  count of retired instructions.

Behaviour:
- Reset (asynchronous, active-high) drives, immediately and for its whole duration:
  - pc_out = RESET_PC, instr = 32'h0000_0013 (NOP), instr_valid = 0, imem_req = 0, fetch_err = 0, instret = 0, state = FETCH.
- Reset mid-operation aborts any outstanding request. A late imem_ready is ignored while rst is high.
- States:
  - FETCH: imem_req = 1, imem_addr = pc_out. On imem_ready: instr <= imem_rdata, instr_valid <= 1, go to HOLD.
  - HOLD: imem_req = 0, instr and pc_out held stable. On instr_ack: pc_out <= next_pc, instret <= instret + 1, instr_valid <= 0, go to FETCH. If next_pc[1:0] != 0, go to HALT instead.
  - HALT: fetch_err = 1, imem_req = 0, instr_valid = 0, PC frozen at the faulting instruction. Only rst leaves HALT.
- Next-PC selection is combinational, evaluated in HOLD:
  - jalr = 1: (rs1_val + imm) & ~32'h1.
  - else br_taken = 1: pc_out + imm.
  - else: pc_out + 4.
  - jalr has priority if both are asserted.
- Arithmetic:
  - All additions are modulo 2^32; wrap-around is legal (e.g. 32'hFFFF_FFFC + 4 = 0).
  - instret wraps from 32'hFFFF_FFFF to 0.
- Latency:
  - First imem_req is asserted in the first cycle after rst deasserts.
  - With zero-wait memory (imem_ready high in the request cycle), instr_valid rises on the next edge.
  - Minimum throughput is one instruction per 2 cycles. Each wait cycle adds one.
- Handshake rules:
  - instr_ack while instr_valid = 0 is ignored.
  - imem_ready while imem_req = 0 is ignored.
  - imem_addr stays stable while imem_req is high and imem_ready is low.
- pc_plus4 is always pc_out + 4, combinational.

Decomposition:
- Shared package (core pkg) holds:
  - fetch state enum: FETCH, HOLD, HALT.
  - NOP_INSTR = 32'h0000_0013.
  - default RESET_PC.
- One sub-module is natural: next_pc_sel, a combinational target mux/adder producing next_pc and a misalign flag.
- The FSM, PC register and instret counter stay in pc_fetch.

Test Plan:
- Reset and sequential fetch: RESET_PC = 0, zero-wait memory, ack every HOLD.
  - First request at addr 0, cycle 1 after reset.
  - imem_addr sequence 0, 4, 8.
  - instret = 3 after three acks.
- Wait states: imem_ready delayed 3 cycles at addr 0x10.
  - imem_addr held at 0x10 with imem_req high for 4 cycles.
  - instr captures rdata 0x00500093 exactly once.
- Branch via genInm: pc_out = 0x20, imm = 32'hFFFF_FFF8, br_taken = 1, ack.
  - Next imem_addr = 0x18.
  - With br_taken = 0, next imem_addr = 0x24.
- JALR priority and bit-0 clear: rs1_val = 0x101, imm = 4, jalr = 1, br_taken = 1, ack.
  - Next imem_addr = 0x104.
- Misaligned target: pc_out = 0x40, imm = 32'h2, br_taken = 1, ack.
  - fetch_err = 1, pc_out stays 0x40, imem_req stays 0 for 10 cycles.
  - rst clears fetch_err and restores pc_out = RESET_PC.
- Asynchronous reset mid-wait: assert rst between clock edges while in FETCH with imem_req high.
  - imem_req falls without waiting for a clock edge.
  - After release, fetch restarts at RESET_PC with instret = 0.
